// File: rtl/bsg_dff_reset_rr_arb.sv
// Round-robin arbiter in front of one shared register: the winner loads its word or clears it,
// and the register remembers which requester touched it last.
module bsg_dff_reset_rr_arb #(
  parameter  int width_p   = 16,
  parameter  int els_p     = 4,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [els_p-1:0]         v_i,
  input  logic [els_p-1:0]         clear_i,
  input  logic [els_p*width_p-1:0] data_i,
  output logic [els_p-1:0]         yumi_o,
  output logic [width_p-1:0]       data_o,
  output logic                     v_o,
  output logic [lg_els_lp-1:0]     owner_o
);

  logic [lg_els_lp-1:0] r_ptr;
  logic [width_p-1:0]   r_data;
  logic                 r_v;
  logic [lg_els_lp-1:0] r_owner;

  logic [els_p-1:0]     w_active;
  logic [els_p-1:0]     w_yumi;
  logic                 w_found;
  logic [lg_els_lp-1:0] w_idx;
  logic                 w_clr;
  logic [width_p-1:0]   w_data;
  logic [lg_els_lp-1:0] w_ptr_nxt;

  assign w_active = v_i | clear_i;

  // Two passes give the rotated search: first the slots at or above the pointer, then the wrap.
  always_comb begin
    w_yumi  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_clr   = 1'b0;
    w_data  = '0;
    for (int k = 0; k < els_p; k++) begin
      if (!w_found && (k >= int'(r_ptr)) && w_active[k]) begin
        w_found   = 1'b1;
        w_yumi[k] = 1'b1;
        w_idx     = lg_els_lp'(k);
        w_clr     = clear_i[k];
        w_data    = data_i[k*width_p +: width_p];
      end
    end
    for (int k = 0; k < els_p; k++) begin
      if (!w_found && w_active[k]) begin
        w_found   = 1'b1;
        w_yumi[k] = 1'b1;
        w_idx     = lg_els_lp'(k);
        w_clr     = clear_i[k];
        w_data    = data_i[k*width_p +: width_p];
      end
    end
  end

  // Explicit wrap so non-power-of-two counts never land on an unused slot.
  assign w_ptr_nxt = (w_idx == lg_els_lp'(els_p-1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_ptr   <= '0;
      r_data  <= '0;
      r_v     <= 1'b0;
      r_owner <= '0;
    end else if (w_found) begin
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_idx;
      if (w_clr) begin
        r_data <= '0;
        r_v    <= 1'b0;
      end else begin
        r_data <= w_data;
        r_v    <= 1'b1;
      end
    end
  end

  assign yumi_o  = reset_n_i ? w_yumi : '0;
  assign data_o  = r_data;
  assign v_o     = r_v;
  assign owner_o = r_owner;

endmodule

// File: tb/tb_bsg_dff_reset_rr_arb.sv
// Directed bench for the round-robin register arbiter: a 4-requester instance and a 3-requester one.
module tb_bsg_dff_reset_rr_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  v = '0, clr = '0, yumi;
  logic [63:0] data = '0;
  logic [15:0] dout;
  logic        vout;
  logic [1:0]  owner;

  logic [2:0]  v3 = '0, clr3 = '0, yumi3;
  logic [47:0] data3 = '0;
  logic [15:0] dout3;
  logic        vout3;
  logic [1:0]  owner3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bsg_dff_reset_rr_arb #(.width_p(16), .els_p(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .clear_i(clr), .data_i(data),
    .yumi_o(yumi), .data_o(dout), .v_o(vout), .owner_o(owner));

  bsg_dff_reset_rr_arb #(.width_p(16), .els_p(3)) dut3 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v3), .clear_i(clr3), .data_i(data3),
    .yumi_o(yumi3), .data_o(dout3), .v_o(vout3), .owner_o(owner3));

  // Advance past the next rising edge; drives and checks happen away from it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; v = 4'hF;
    data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    tick(); tick();
    checks++; if (yumi !== 4'b0000) begin errors++; $display("FAIL rst_yumi got=%b exp=0000", yumi); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL rst_data got=%h exp=0000", dout); end
    checks++; if (vout !== 1'b0) begin errors++; $display("FAIL rst_v got=%b exp=0", vout); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rst_owner got=%0d exp=0", owner); end
    reset_n = 1'b1; #1;
    checks++; if (yumi !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got=%b exp=0001", yumi); end
    tick(); v = '0;
    checks++; if (dout !== 16'h1111 || owner !== 2'd0 || vout !== 1'b1)
      begin errors++; $display("FAIL rst_first_write got=%h/%0d/%b exp=1111/0/1", dout, owner, vout); end
  endtask

  task automatic test_single();
    v = 4'b0100; data[32 +: 16] = 16'hA5C3; #1;
    checks++; if (yumi !== 4'b0100) begin errors++; $display("FAIL single_yumi got=%b exp=0100", yumi); end
    tick(); v = '0; #1;
    checks++; if (dout !== 16'hA5C3) begin errors++; $display("FAIL single_data got=%h exp=a5c3", dout); end
    checks++; if (vout !== 1'b1) begin errors++; $display("FAIL single_v got=%b exp=1", vout); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL single_owner got=%0d exp=2", owner); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] exp_dat [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    v = 4'hF; data = {16'h4444, 16'h3333, 16'h2222, 16'h1111}; #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (yumi !== (4'b0001 << exp_idx[i]))
        begin errors++; $display("FAIL cont_yumi[%0d] got=%b exp=%b", i, yumi, 4'b0001 << exp_idx[i]); end
      tick();
      checks++; if (dout !== exp_dat[i] || owner !== exp_idx[i])
        begin errors++; $display("FAIL cont_data[%0d] got=%h/%0d exp=%h/%0d", i, dout, owner, exp_dat[i], exp_idx[i]); end
    end
    v = '0;
  endtask

  task automatic test_clear();
    v = 4'b0010; data[16 +: 16] = 16'hBEEF; tick(); v = '0; #1;
    checks++; if (dout !== 16'hBEEF) begin errors++; $display("FAIL clr_setup got=%h exp=beef", dout); end
    v = 4'b0010; clr = 4'b0010; #1;
    checks++; if (yumi !== 4'b0010) begin errors++; $display("FAIL clr_yumi got=%b exp=0010", yumi); end
    tick(); v = '0; clr = '0; #1;
    checks++; if (dout !== 16'h0 || vout !== 1'b0 || owner !== 2'd1)
      begin errors++; $display("FAIL clr_result got=%h/%b/%0d exp=0000/0/1", dout, vout, owner); end
  endtask

  task automatic test_reset_mid();
    v = 4'b0100; tick();
    v = 4'hF; #1;
    checks++; if (yumi !== 4'b1000) begin errors++; $display("FAIL mid_ptr3 got=%b exp=1000", yumi); end
    reset_n = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (yumi !== 4'b0000) begin errors++; $display("FAIL mid_yumi[%0d] got=%b exp=0000", i, yumi); end
      tick();
    end
    checks++; if (dout !== 16'h0 || vout !== 1'b0 || owner !== 2'd0)
      begin errors++; $display("FAIL mid_outs got=%h/%b/%0d exp=0000/0/0", dout, vout, owner); end
    reset_n = 1'b1; #1;
    checks++; if (yumi !== 4'b0001) begin errors++; $display("FAIL mid_first got=%b exp=0001", yumi); end
    tick(); v = '0;
    checks++; if (owner !== 2'd0 || dout !== 16'h1111)
      begin errors++; $display("FAIL mid_write got=%h/%0d exp=1111/0", dout, owner); end
  endtask

  task automatic test_npot();
    logic [1:0] exp_idx [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [15:0] exp_dat;
    data3 = {16'hCCCC, 16'hBBBB, 16'hAAAA}; v3 = 3'b101; #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (yumi3 !== (3'b001 << exp_idx[i]))
        begin errors++; $display("FAIL npot_yumi[%0d] got=%b exp=%b", i, yumi3, 3'b001 << exp_idx[i]); end
      tick();
      exp_dat = (exp_idx[i] == 2'd0) ? 16'hAAAA : 16'hCCCC;
      checks++; if (owner3 !== exp_idx[i] || dout3 !== exp_dat || owner3 > 2'd2)
        begin errors++; $display("FAIL npot_out[%0d] got=%h/%0d exp=%h/%0d", i, dout3, owner3, exp_dat, exp_idx[i]); end
    end
    v3 = '0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3] = '{16'h0F0F, 16'h1234, 16'hFFFF};
    v = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      data[0 +: 16] = words[i]; #1;
      checks++; if (yumi !== 4'b0001) begin errors++; $display("FAIL b2b_yumi[%0d] got=%b exp=0001", i, yumi); end
      tick();
      checks++; if (dout !== words[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, dout, words[i]); end
    end
    v = '0; #1;
    checks++; if (yumi !== 4'b0000) begin errors++; $display("FAIL idle_yumi got=%b exp=0000", yumi); end
    tick();
    checks++; if (dout !== 16'hFFFF || owner !== 2'd0)
      begin errors++; $display("FAIL idle_hold got=%h/%0d exp=ffff/0", dout, owner); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_clear();
    test_reset_mid();
    test_npot();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
